// File: rtl/uart_tx_if.sv
// Parallel-side handshake of the UART transmitter: word request in, busy/done status out.
interface uart_tx_if #(
   parameter int DBIT = 8
) ();
   logic            tx_start;
   logic [DBIT-1:0] tx_din;
   logic            tx_busy;
   logic            tx_done_tick;

   modport master (output tx_start, output tx_din, input tx_busy, input tx_done_tick);
   modport slave  (input tx_start, input tx_din, output tx_busy, output tx_done_tick);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period,
// paced by a 16x oversampling baud tick.
module uart_tx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     s_tick,
   uart_tx_if.slave bus,
   output logic     tx
);
   localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int SW    = $clog2(S_MAX);
   localparam int NW    = $clog2(DBIT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state, state_next;
   logic [SW-1:0]   s, s_next;
   logic [NW-1:0]   n, n_next;
   logic [DBIT-1:0] b, b_next;
   logic            tx_reg, tx_next;
   logic            done_reg, done_next;
   logic            par_reg, par_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         s        <= '0;
         n        <= '0;
         b        <= '0;
         tx_reg   <= 1'b1;
         done_reg <= 1'b0;
         par_reg  <= 1'b0;
      end else begin
         state    <= state_next;
         s        <= s_next;
         n        <= n_next;
         b        <= b_next;
         tx_reg   <= tx_next;
         done_reg <= done_next;
         par_reg  <= par_next;
      end
   end

   always_comb begin
      state_next = state;
      s_next     = s;
      n_next     = n;
      b_next     = b;
      tx_next    = tx_reg;
      done_next  = 1'b0;
      par_next   = par_reg;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (bus.tx_start) begin
               state_next = START;
               s_next     = '0;
               b_next     = bus.tx_din;
               par_next   = (^bus.tx_din) ^ (PARITY_ODD != 0);
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s == SW'(15)) begin
                  state_next = DATA;
                  s_next     = '0;
                  n_next     = '0;
                  tx_next    = b[0];
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == SW'(15)) begin
                  s_next = '0;
                  b_next = b >> 1;
                  if (n == NW'(DBIT - 1)) begin
                     if (PARITY_EN != 0) begin
                        state_next = PARITY;
                        tx_next    = par_reg;
                     end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                     end
                  end else begin
                     n_next  = n + NW'(1);
                     // b[1] becomes b[0] after this shift, so drive it now
                     tx_next = b[1];
                  end
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s == SW'(15)) begin
                  state_next = STOP;
                  s_next     = '0;
                  tx_next    = 1'b1;
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s == SW'(SB_TICK - 1)) begin
                  state_next = IDLE;
                  s_next     = '0;
                  done_next  = 1'b1;
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            s_next     = '0;
            n_next     = '0;
            b_next     = '0;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign tx               = tx_reg;
   assign bus.tx_busy      = (state != IDLE);
   assign bus.tx_done_tick = done_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven in parallel, checked every cycle
// against a tick-counting frame model plus hand-computed timing/level expectations.
module tb_uart_tx;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_tick = 1'b0;
   logic       tick_en = 1'b1;
   int         tcnt = 0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_din = '0;

   logic [3:0] tx_v, busy_v, done_v;

   int errors = 0;
   int checks = 0;

   // configuration per instance: parity enable, parity odd, stop ticks
   int cfg_pen [4] = '{0, 1, 1, 0};
   int cfg_podd[4] = '{0, 0, 1, 0};
   int cfg_sb  [4] = '{16, 16, 16, 32};

   // model state
   logic        m_busy[4];
   logic        m_done[4];
   int          m_k[4];
   logic [15:0] m_bits[4];
   int          m_nb[4];
   int          m_total[4];

   int  done_cnt[4];
   time done_time[4];
   time t_acc;

   uart_tx_if #(.DBIT(8)) if0 (), if1 (), if2 (), if3 ();

   assign if0.tx_start = tx_start;
   assign if1.tx_start = tx_start;
   assign if2.tx_start = tx_start;
   assign if3.tx_start = tx_start;
   assign if0.tx_din = tx_din;
   assign if1.tx_din = tx_din;
   assign if2.tx_din = tx_din;
   assign if3.tx_din = tx_din;
   assign busy_v = {if3.tx_busy, if2.tx_busy, if1.tx_busy, if0.tx_busy};
   assign done_v = {if3.tx_done_tick, if2.tx_done_tick, if1.tx_done_tick, if0.tx_done_tick};

   uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus(if0.slave), .tx(tx_v[0]));
   uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus(if1.slave), .tx(tx_v[1]));
   uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus(if2.slave), .tx(tx_v[2]));
   uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus(if3.slave), .tx(tx_v[3]));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // tick generator: one tick in every four clocks, updated 1 time unit after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tcnt   = (tcnt + 1) % 4;
         s_tick = tick_en && (tcnt == 3);
      end
   end

   function automatic logic exp_tx(input int i);
      if (!m_busy[i]) return 1'b1;
      if (m_k[i] / 16 < m_nb[i]) return m_bits[i][m_k[i] / 16];
      return 1'b1;
   endfunction

   // model update at each edge, compare at each falling edge
   initial begin
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 0; m_done[i] = 0; m_k[i] = 0; m_bits[i] = '0;
         m_nb[i] = 0; m_total[i] = 0; done_cnt[i] = 0; done_time[i] = 0;
      end
      forever begin
         @(posedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
               m_busy[i] = 0; m_done[i] = 0; m_k[i] = 0;
            end else begin
               m_done[i] = 0;
               if (m_busy[i]) begin
                  if (s_tick) begin
                     m_k[i]++;
                     if (m_k[i] == m_total[i]) begin
                        m_busy[i] = 0;
                        m_done[i] = 1;
                     end
                  end
               end else if (tx_start) begin
                  m_busy[i] = 1;
                  m_k[i]    = 0;
                  m_bits[i] = '1;
                  m_bits[i][0] = 1'b0;
                  for (int j = 0; j < 8; j++) m_bits[i][1 + j] = tx_din[j];
                  if (cfg_pen[i] != 0) m_bits[i][9] = (^tx_din) ^ (cfg_podd[i] != 0);
                  m_nb[i]    = 9 + cfg_pen[i];
                  m_total[i] = m_nb[i] * 16 + cfg_sb[i];
               end
            end
         end
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
               m_busy[i] = 0; m_done[i] = 0; m_k[i] = 0;
            end
            chk($sformatf("tx[%0d]", i), longint'(tx_v[i]), longint'(exp_tx(i)));
            chk($sformatf("busy[%0d]", i), longint'(busy_v[i]), longint'(m_busy[i]));
            chk($sformatf("done[%0d]", i), longint'(done_v[i]), longint'(m_done[i]));
            if (done_v[i]) begin
               done_cnt[i]++;
               done_time[i] = $time;
            end
         end
      end
   end

   // request a frame so the accepting edge also samples a tick
   task automatic send(input logic [7:0] din, input logic hold);
      do begin
         @(posedge clk);
         #2;
      end while (tcnt != 3);
      for (int i = 0; i < 4; i++) done_cnt[i] = 0;
      tx_din   = din;
      tx_start = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #2;
      if (!hold) tx_start = 1'b0;
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      while (busy_v != 4'b0000 && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      if (busy_v != 4'b0000) chk("idle_timeout", longint'(busy_v), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [9:0] seq_a5;
      int cnt;
      seq_a5 = 10'b1101001010; // bit j = level of frame bit j for 0xA5

      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_tx", longint'(tx_v), 15);
      chk("reset_busy", longint'(busy_v), 0);
      chk("reset_done", longint'(done_v), 0);

      // basic frame 0xA5
      send(8'hA5, 1'b0);
      for (int j = 0; j < 10; j++) begin
         repeat ((j == 0) ? 32 : 64) @(negedge clk);
         chk($sformatf("a5_bit%0d", j), longint'(tx_v[0]), longint'(seq_a5[j]));
         if (j < 9) chk($sformatf("a5_busy%0d", j), longint'(busy_v[0]), 1);
      end
      wait_idle();
      chk("a5_done_cnt", done_cnt[0], 1);
      chk("a5_done_time", longint'(done_time[0] - t_acc), 6405);

      // parity frame 0x07
      send(8'h07, 1'b0);
      repeat (32 + 64 * 9) @(negedge clk);
      chk("par_even", longint'(tx_v[1]), 1);
      chk("par_odd", longint'(tx_v[2]), 0);
      chk("par_nopar_stop", longint'(tx_v[0]), 1);
      wait_idle();
      chk("par_even_time", longint'(done_time[1] - t_acc), 7045);
      chk("par_odd_time", longint'(done_time[2] - t_acc), 7045);
      chk("sb32_time", longint'(done_time[3] - t_acc), 7045);
      chk("sb32_done_cnt", done_cnt[3], 1);
      chk("nopar_time", longint'(done_time[0] - t_acc), 6405);

      // back-to-back with held start and mid-frame input changes
      send(8'h55, 1'b1);
      repeat (200) @(negedge clk);
      tx_din = 8'hFF;
      repeat (200) @(negedge clk);
      tx_din = 8'h0F;
      cnt = 0;
      while (!done_v[0] && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      chk("b2b_done_seen", longint'(done_v[0]), 1);
      chk("b2b_stop_level", longint'(tx_v[0]), 1);
      @(negedge clk);
      chk("b2b_restart_tx", longint'(tx_v[0]), 0);
      chk("b2b_restart_busy", longint'(busy_v[0]), 1);
      repeat (80) @(negedge clk);
      tx_start = 1'b0;
      repeat (300) @(negedge clk);
      tx_din   = 8'hFF;
      tx_start = 1'b1;
      repeat (5) @(negedge clk);
      tx_start = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++) chk($sformatf("b2b_frames[%0d]", i), done_cnt[i], 2);

      // reset during data bit 3
      send(8'hA5, 1'b0);
      repeat (280) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tx", longint'(tx_v), 15);
      chk("rst_busy", longint'(busy_v), 0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("rst_idle_tx", longint'(tx_v), 15);
      chk("rst_idle_busy", longint'(busy_v), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_no_done[%0d]", i), done_cnt[i], 0);

      // sparse ticks: 100 clocks without ticks in the middle of data bit 0
      send(8'hA5, 1'b0);
      repeat (100) @(negedge clk);
      @(posedge clk);
      #2 tick_en = 1'b0;
      repeat (100) @(posedge clk);
      #2 tick_en = 1'b1;
      wait_idle();
      chk("sparse_done_cnt", done_cnt[0], 1);
      chk("sparse_done_time", longint'(done_time[0] - t_acc), 7405);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
